// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data load/store.
// Each access holds its strobe for MEM_LATENCY cycles, then pulses a valid.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_valid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 busy,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_IF  = 3'd1,
    ACC_DRD = 3'd2,
    ACC_DWR = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 if_valid_q, if_valid_d;
  logic                 d_valid_q, d_valid_d;
  logic                 pick_if, pick_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    read_d       = read_q;
    write_d      = write_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    // On a tie the side that did not win last time gets the bus.
    pick_if      = if_req && (!d_req || (last_grant_q == GRANT_DATA));
    pick_data    = d_req && !pick_if;

    case (state_q)
      IDLE: begin
        if (pick_if) begin
          state_d      = ACC_IF;
          addr_d       = if_addr;
          cnt_d        = CNT_INIT;
          last_grant_d = GRANT_FETCH;
          read_d       = 1'b1;
        end else if (pick_data) begin
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          cnt_d        = CNT_INIT;
          last_grant_d = GRANT_DATA;
          if (d_we) begin
            state_d = ACC_DWR;
            write_d = 1'b1;
          end else begin
            state_d = ACC_DRD;
            read_d  = 1'b1;
          end
        end
      end
      ACC_IF, ACC_DRD, ACC_DWR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
          // Read data is captured on the same edge the strobe drops.
          if (state_q == ACC_IF) begin
            if_rdata_d = data;
            if_valid_d = 1'b1;
          end else begin
            if (state_q == ACC_DRD) d_rdata_d = data;
            d_valid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
    end
  end

  assign readM    = read_q;
  assign writeM   = write_q;
  assign address  = addr_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);
  assign data     = write_q ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the CPU's single 16-bit memory bus between two requesters: the instruction-fetch path and the data (load/store) path of the multi-cycle datapath. It drives readM, writeM, address and the bidirectional data bus, and holds each access for a fixed memory latency. It returns read data through a one-cycle valid pulse and alternates grants under contention so neither side starves. It sits between the cpu datapath/control FSM and the external memory.

Parameters:
WORD_SIZE, 16, data/address width.
MEM_LATENCY, 2, number of cycles readM/writeM stay asserted per access. Must be >= 1.

Ports:
Clk  input  1  system clock; all state changes on posedge.
Reset  input  1  asynchronous, active-high reset.
if_req  input  1  fetch request; level, held until if_valid.
if_addr  input  WORD_SIZE  fetch address; sampled at grant.
if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid.
if_rdata  output  WORD_SIZE  fetched instruction; registered, held until next fetch completes.
d_req  input  1  data request; level, held until d_valid.
d_we  input  1  1 = store, 0 = load; sampled at grant.
d_addr  input  WORD_SIZE  data address; sampled at grant.
d_wdata  input  WORD_SIZE  store data; sampled at grant.
d_valid  output  1  one-cycle pulse: data access complete.
d_rdata  output  WORD_SIZE  load result; registered, updated only on load completion.
busy  output  1  high in any state other than IDLE.
readM  output  1  memory read strobe.
writeM  output  1  memory write strobe.
address  output  WORD_SIZE  memory address.
data  inout  WORD_SIZE  memory data bus; driven only while writeM=1, else high-Z.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, readM=writeM=0, address=0, data=Z, if_valid=d_valid=0, if_rdata=d_rdata=0, cnt=0, last_grant=FETCH, busy=0. Reset mid-access aborts immediately; no valid pulse is issued for the aborted access.
- States: IDLE, ACC_IF, ACC_DRD, ACC_DWR, DONE. All outputs are registered.
- IDLE: at a posedge, choose the grant:
  - if_req only: go to ACC_IF.
  - d_req only: go to ACC_DRD if d_we=0, else ACC_DWR.
  - Both high: grant the side opposite last_grant. After reset, data wins the first tie.
  - On grant: latch the address and wdata into address/wdata registers, set cnt=MEM_LATENCY-1, update last_grant, and assert readM (ACC_IF/ACC_DRD) or writeM (ACC_DWR) from the next cycle.
- ACC_*: strobe and address stay constant. Each posedge with cnt!=0 decrements cnt. At the posedge with cnt==0:
  - Deassert the strobe and release data to Z.
  - For reads, capture the data bus into if_rdata or d_rdata.
  - Go to DONE and raise the matching valid.
  - Net effect: the strobe is high for exactly MEM_LATENCY cycles.
- DONE: exactly one cycle with the valid pulse high and the bus idle (readM=writeM=0). Next posedge: go to IDLE and clear valid. The requester must drop or renew its req by that edge. A req still high is treated as a new request, arbitrated at the IDLE edge that follows.
- Latency: from the req-sampling edge to valid rising is MEM_LATENCY+1 edges. Minimum spacing between grants is MEM_LATENCY+2 cycles.
- readM and writeM are never high simultaneously. data is never driven while readM=1.
- A req deasserted during ACC_* does not cancel the access; the access completes and valid still pulses.
- Input changes to addr/wdata/d_we after grant are ignored.
- A store does not modify d_rdata or if_rdata.

Test Plan:
- Reset: assert Reset mid-cycle with no clock edge -> immediately readM=writeM=0, data=Z, busy=0, both valids 0, both rdata=0x0000.
- Fetch (MEM_LATENCY=2): if_req=1, if_addr=0x0000, memory returns 0x6001 -> address=0x0000 and readM=1 for exactly 2 cycles; if_valid pulses 1 cycle at edge 3 after grant; if_rdata=0x6001 and held afterward.
- Store: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> writeM=1 for 2 cycles, data=0x1234 only during those cycles, readM=0 throughout, d_valid pulses once, d_rdata unchanged.
- Contention: after reset, hold if_req=d_req=1 (d_we=0, d_addr=0x0010 returns 0xBEEF; if_addr=0x0002) -> grant order is data, fetch, data. Valid pulses alternate; d_rdata=0xBEEF.
- Reset mid-access: assert Reset during the 1st cycle of ACC_DWR -> writeM drops at once, data=Z, no d_valid. After release with no req, the FSM stays in IDLE.
- Req dropped mid-access plus MEM_LATENCY=1 variant: drop if_req during ACC_IF -> access completes and if_valid still pulses. With MEM_LATENCY=1, readM is high for exactly 1 cycle.
